alu_exec_seq: RTL
=================

// Module: alu_exec_seq
// PURPOSE
//  Parametrised execute stage: decodes alu_op/fun3/fun7 and computes the result in one block.
//  Handles RV base integer ops (R, I, branch-compare, address add) plus optional iterative RV-M mul/div.
//  Sits between the decode/issue stage and writeback; valid/ready on both sides.
//  Simple ops: 1 cycle. Mul/div: XLEN+1 cycles, multi-cycle FSM.
// PARAMETERS
//  XLEN  32  datapath width; power of two, >=8; shift amount = op_b[$clog2(XLEN)-1:0]
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst_n      in   1     synchronous, active-low reset
//  in_valid   in   1     issue side: operation offered
//  in_ready   out  1     issue side: operation accepted when in_valid&in_ready
//  alu_op     in   2     00 addr-add, 01 branch compare, 10 R-type, 11 I-type (OP-IMM)
//  fun3       in   3     instruction funct3
//  fun7       in   7     instruction funct7 (I-type: only fun7[5], shifts only)
//  op_a       in   XLEN  rs1 operand
//  op_b       in   XLEN  rs2 or immediate operand
//  out_valid  out  1     writeback side: result/zero/illegal valid
//  out_ready  in   1     writeback side: consumer accepts
//  result     out  XLEN  registered result
//  zero       out  1     registered (result==0); used for beq/bne
//  illegal    out  1     registered: encoding not supported; result forced to 0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0 during reset cycle, out_valid=0, result=0, zero=0, illegal=0, counter=0.
//  FSM: IDLE -> (accept simple/illegal) DONE; IDLE -> (accept M op) BUSY; BUSY -> (counter==XLEN-1) DONE;
//   DONE -> (out_ready & !in_valid) IDLE; DONE -> (out_ready & in_valid) accept new op, same rules as IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Never asserted in BUSY.
//  Outputs held stable while out_valid & !out_ready. Inputs sampled only on accept.
//  Decode: 00 -> ADD. 01 -> beq/bne SUB, blt/bge SLT, bltu/bgeu SLTU, fun3 010/011 illegal.
//   10 -> {fun7[5],fun3}: ADD,SUB,SLL,SLT,SLTU,XOR,SRL(0101),SRA(1101),OR,AND; fun7 other than
//   0000000/0100000 (or 0000001 for M) illegal; fun7[5]=1 with fun3 not 000/101 illegal.
//   11 -> ADDI..ANDI per fun3; SUB never; SRLI/SRAI by fun7[5]; fun3=001 with fun7!=0 illegal.
//  SLT/SLTU result: zero-extended 1-bit. All arithmetic mod 2^XLEN, no overflow flag.
//  Latency: simple op out_valid exactly 1 cycle after accept; M op exactly XLEN+1 cycles after accept.
//  M ops (fun7=0000001, alu_op=10): fun3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU,
//   110 REM, 111 REMU. Iterative shift-add / restoring divide on magnitudes, 1 bit per cycle, sign fixed in DONE.
//  Div by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a. Signed overflow (MIN/-1): quotient = MIN,
//   remainder = 0. Special cases still take XLEN+1 cycles (fixed latency).
//  Reset mid-op: rst_n low in BUSY/DONE aborts; next cycle IDLE with reset values, no result produced.
// CONFIGURATION
//  RV_M_EXT_EN defined: M ops supported, BUSY state and iterative datapath compiled in.
//  RV_M_EXT_EN undefined: fun7=0000001 decodes illegal (1-cycle, result 0, illegal=1); FSM is IDLE/DONE only.
// TESTING
//  alu_op=10,fun7=0x20,fun3=000,a=5,b=7, out_ready=1 -> 1 cycle later out_valid, result=0xFFFFFFFE, zero=0.
//  alu_op=01,fun3=000,a=b=0x1234 -> result=0, zero=1; fun3=110,a=1,b=0xFFFFFFFF -> result=1.
//  alu_op=11,fun3=101,fun7=0x20,a=0x80000000,b=4 -> result=0xF8000000; same with fun7=0 -> 0x08000000.
//  [RV_M_EXT_EN] MULH a=0xFFFFFFFF,b=2 -> out_valid 33 cycles after accept, result=0xFFFFFFFF; in_ready=0 in BUSY.
//  [RV_M_EXT_EN] DIV a=0x80000000,b=0xFFFFFFFF -> 0x80000000; REMU a=9,b=0 -> 9; DIVU a=9,b=0 -> 0xFFFFFFFF.
//  out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; rst_n=0 mid-BUSY -> out_valid=0, state IDLE.

Source files
------------

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: RV integer execute stage with valid/ready on issue and writeback sides.
// Iterative RV-M multiply/divide is compiled in only when RV_M_EXT_EN is defined.
module alu_exec_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      fun3,
    input  logic [6:0]      fun7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int unsigned SHW = $clog2(XLEN);

`ifdef RV_M_EXT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

    typedef enum logic [3:0] {
        F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA, F_OR, F_AND
    } fn_e;

    state_e          state, state_d;
    logic            out_valid_d, zero_d, illegal_d;
    logic [XLEN-1:0] result_d;
    logic            accept;
    fn_e             fn;
    logic            dec_illegal;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] simple_res;

    function automatic fn_e base_fn(input logic [2:0] f3);
        case (f3)
            3'b000:  base_fn = F_ADD;
            3'b001:  base_fn = F_SLL;
            3'b010:  base_fn = F_SLT;
            3'b011:  base_fn = F_SLTU;
            3'b100:  base_fn = F_XOR;
            3'b101:  base_fn = F_SRL;
            3'b110:  base_fn = F_OR;
            default: base_fn = F_AND;
        endcase
    endfunction

    assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign shamt    = op_b[SHW-1:0];

`ifdef RV_M_EXT_EN
    logic            dec_m;
    logic [XLEN-1:0] hi, hi_d, hi_n, lo, lo_d, lo_n, mcand, mcand_d, m_res;
    logic [SHW-1:0]  cnt, cnt_d;
    logic [2:0]      m_fun3, m_fun3_d;
    logic            m_neg_q, m_neg_q_d, m_neg_r, m_neg_r_d;
    logic            m_sa, m_sb, neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
`endif

    // Decode alu_op/fun3/fun7 into a simple function or an M-extension request
    always_comb begin
        fn          = F_ADD;
        dec_illegal = 1'b0;
`ifdef RV_M_EXT_EN
        dec_m       = 1'b0;
`endif
        case (alu_op)
            2'b00: fn = F_ADD;
            2'b01: begin
                case (fun3[2:1])
                    2'b00:   fn = F_SUB;
                    2'b10:   fn = F_SLT;
                    2'b11:   fn = F_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                if (fun7 == 7'b0000000) begin
                    fn = base_fn(fun3);
                end else if (fun7 == 7'b0100000) begin
                    if (fun3 == 3'b000)      fn = F_SUB;
                    else if (fun3 == 3'b101) fn = F_SRA;
                    else                     dec_illegal = 1'b1;
                end else if (fun7 == 7'b0000001) begin
`ifdef RV_M_EXT_EN
                    dec_m = 1'b1;
`else
                    dec_illegal = 1'b1;
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                fn = base_fn(fun3);
                if ((fun3 == 3'b001) && (fun7 != 7'b0000000)) dec_illegal = 1'b1;
                if ((fun3 == 3'b101) && fun7[5])              fn = F_SRA;
            end
        endcase
    end

    always_comb begin
        simple_res = '0;
        case (fn)
            F_ADD:   simple_res = op_a + op_b;
            F_SUB:   simple_res = op_a - op_b;
            F_SLL:   simple_res = op_a << shamt;
            F_SLT:   simple_res = XLEN'($signed(op_a) < $signed(op_b));
            F_SLTU:  simple_res = XLEN'(op_a < op_b);
            F_XOR:   simple_res = op_a ^ op_b;
            F_SRL:   simple_res = op_a >> shamt;
            F_SRA:   simple_res = XLEN'($signed(op_a) >>> shamt);
            F_OR:    simple_res = op_a | op_b;
            F_AND:   simple_res = op_a & op_b;
            default: simple_res = '0;
        endcase
    end

`ifdef RV_M_EXT_EN
    // Operand signs and magnitudes captured at accept
    always_comb begin
        m_sa     = (fun3 == 3'b001) || (fun3 == 3'b010) || (fun3 == 3'b100) || (fun3 == 3'b110);
        m_sb     = (fun3 == 3'b001) || (fun3 == 3'b100) || (fun3 == 3'b110);
        neg_a_in = m_sa & op_a[XLEN-1];
        neg_b_in = m_sb & op_b[XLEN-1];
        mag_a_in = neg_a_in ? -op_a : op_a;
        mag_b_in = neg_b_in ? -op_b : op_b;
    end

    // One shift-add or restoring-divide step, plus sign fix-up for the final step
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, mcand};
        if (!m_fun3[2]) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            hi_n = div_diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_n = div_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
        end
        prod   = {hi_n, lo_n};
        prod_s = m_neg_q ? -prod : prod;
        case (m_fun3)
            3'b000:         m_res = prod_s[XLEN-1:0];
            3'b100, 3'b101: m_res = m_neg_q ? -lo_n : lo_n;
            3'b110, 3'b111: m_res = m_neg_r ? -hi_n : hi_n;
            default:        m_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        out_valid_d = out_valid;
        result_d    = result;
        zero_d      = zero;
        illegal_d   = illegal;
`ifdef RV_M_EXT_EN
        hi_d        = hi;
        lo_d        = lo;
        mcand_d     = mcand;
        cnt_d       = cnt;
        m_fun3_d    = m_fun3;
        m_neg_q_d   = m_neg_q;
        m_neg_r_d   = m_neg_r;
`endif
        case (state)
            IDLE, DONE: begin
                if ((state == DONE) && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
`ifdef RV_M_EXT_EN
                    if (dec_m) begin
                        state_d     = BUSY;
                        out_valid_d = 1'b0;
                        hi_d        = '0;
                        lo_d        = fun3[2] ? mag_a_in : mag_b_in;
                        mcand_d     = fun3[2] ? mag_b_in : mag_a_in;
                        cnt_d       = '0;
                        m_fun3_d    = fun3;
                        m_neg_q_d   = (neg_a_in ^ neg_b_in) & ~(fun3[2] & (op_b == '0));
                        m_neg_r_d   = neg_a_in;
                    end else
`endif
                    begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = dec_illegal ? '0 : simple_res;
                        zero_d      = dec_illegal | (simple_res == '0);
                        illegal_d   = dec_illegal;
                    end
                end
            end
`ifdef RV_M_EXT_EN
            BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt + SHW'(1);
                if (cnt == SHW'(XLEN - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = m_res;
                    zero_d      = (m_res == '0);
                    illegal_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef RV_M_EXT_EN
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            cnt       <= '0;
            m_fun3    <= '0;
            m_neg_q   <= 1'b0;
            m_neg_r   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            out_valid <= out_valid_d;
            result    <= result_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
`ifdef RV_M_EXT_EN
            hi        <= hi_d;
            lo        <= lo_d;
            mcand     <= mcand_d;
            cnt       <= cnt_d;
            m_fun3    <= m_fun3_d;
            m_neg_q   <= m_neg_q_d;
            m_neg_r   <= m_neg_r_d;
`endif
        end
    end

endmodule
